pcpu_stim_player: RTL and testbench

PCPU_STIM_PLAYER -- requirements
Module: pcpu_stim_player

---
 rtl/pcpu_stim_player_pkg.sv | 32 +++
 rtl/pcpu_stim_player_if.sv | 24 ++
 rtl/pcpu_store_checker.sv | 62 ++++++
 rtl/pcpu_stim_player.sv | 195 +++++++++++++++++++
 tb/tb_pcpu_stim_player.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pcpu_stim_player_pkg.sv
// rtl/pcpu_stim_player_pkg.sv - shared opcodes, word encodings and state/load-select types for the stimulus player
package pcpu_stim_player_pkg;

    // Opcode occupies the top OPC_W bits of every instruction word; operands fill the rest.
    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'h3;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        LD_INSTR    = 2'd0,
        LD_DATA     = 2'd1,
        LD_EXP_ADDR = 2'd2,
        LD_EXP_DATA = 2'd3
    } ld_sel_e;

    function automatic logic is_halt(input logic [OPC_W-1:0] opc);
        return opc == OP_HALT;
    endfunction

endpackage

// File: rtl/pcpu_stim_player_if.sv
// rtl/pcpu_stim_player_if.sv - CPU-side fetch/data bus between the stimulus player (master) and the CPU (slave)
interface pcpu_stim_player_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              cpu_enable;
    logic              cpu_start;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_datain;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_dataout;
    logic              d_we;
    logic [DATA_W-1:0] d_datain;

    modport master (
        output cpu_enable, cpu_start, i_datain, d_datain,
        input  i_addr, d_addr, d_dataout, d_we
    );

    modport slave (
        input  cpu_enable, cpu_start, i_datain, d_datain,
        output i_addr, d_addr, d_dataout, d_we
    );
endinterface

// File: rtl/pcpu_store_checker.sv
// rtl/pcpu_store_checker.sv - compares CPU stores against a loaded list of expected address/data pairs
module pcpu_store_checker
    import pcpu_stim_player_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int EXP_DEPTH = 8,
    localparam int EIDX_W   = $clog2(EXP_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              chk_en,
    input  logic              ld_we,
    input  logic [1:0]        ld_sel,
    input  logic [EIDX_W-1:0] ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [EIDX_W:0]   exp_len,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic              st_err,
    output logic              ptr_done
);
    localparam logic [EIDX_W:0] PTR_MAX = (EIDX_W+1)'(EXP_DEPTH);
    localparam logic [EIDX_W:0] PTR_ONE = (EIDX_W+1)'(1);

    logic [ADDR_W-1:0] exp_addr_mem [EXP_DEPTH];
    logic [DATA_W-1:0] exp_data_mem [EXP_DEPTH];
    logic [EIDX_W:0]   ptr_q;
    logic [EIDX_W-1:0] ptr_idx;
    logic              in_range;
    logic              hit;
    logic              store;

    // Expected lists survive reset so a bench can reload only what changes.
    always_ff @(posedge clock) begin
        if (ld_we && ld_sel == LD_EXP_ADDR)
            exp_addr_mem[ld_idx] <= ld_data[ADDR_W-1:0];
        if (ld_we && ld_sel == LD_EXP_DATA)
            exp_data_mem[ld_idx] <= ld_data;
    end

    assign ptr_idx  = ptr_q[EIDX_W-1:0];
    assign in_range = ptr_q < PTR_MAX;
    assign store    = chk_en && d_we;
    assign hit      = in_range && (ptr_q < exp_len)
                      && (exp_addr_mem[ptr_idx] == d_addr)
                      && (exp_data_mem[ptr_idx] == d_dataout);
    assign st_err   = store && !hit;
    assign ptr_done = ptr_q == exp_len;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ptr_q <= '0;
        else if (clr)
            ptr_q <= '0;
        else if (store && in_range)
            ptr_q <= ptr_q + PTR_ONE;
    end

endmodule

// File: rtl/pcpu_stim_player.sv
// rtl/pcpu_stim_player.sv - replays a loaded program/data image to a CPU; store checker built only with PCPU_STIM_CHECK_EN
module pcpu_stim_player
    import pcpu_stim_player_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 32,
    parameter int EXP_DEPTH = 8,
    parameter int DRAIN     = 8,
    parameter int TIMEOUT   = 1024,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int EIDX_W   = $clog2(EXP_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic               mode,
    input  logic               ld_we,
    input  logic [1:0]         ld_sel,
    input  logic [IDX_W-1:0]   ld_idx,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic [IDX_W:0]     prog_len,
    input  logic [EIDX_W:0]    exp_len,
    pcpu_stim_player_if.master cpu,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_cnt
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int DRN_W = $clog2(DRAIN + 1);
    localparam logic [DATA_W-1:0] NOP_WORD = {OP_NOP, {(DATA_W-OPC_W){1'b0}}};
    localparam logic [IDX_W:0]    PL_ONE   = (IDX_W+1)'(1);

    state_e            state_q, state_d;
    logic              mode_q;
    logic [IDX_W-1:0]  idx_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [DRN_W-1:0]  drn_q;
    logic [DATA_W-1:0] i_q, d_q;
    logic [7:0]        err_q;
    logic [8:0]        err_sum;

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];

    logic ld_ok, go_clr, in_play, tmo_hit, tmo_inc, run_end, drain_end;
    logic start_o, enable_o;
    logic st_err, ptr_done;

    assign ld_ok     = ld_we && (state_q == ST_IDLE || state_q == ST_DONE);
    assign go_clr    = go && (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_play   = state_q == ST_START || state_q == ST_RUN || state_q == ST_DRAIN;
    assign tmo_hit   = tmo_q == TMO_W'(TIMEOUT - 1);
    assign tmo_inc   = (state_q == ST_RUN) && tmo_hit;
    assign drain_end = drn_q == DRN_W'(DRAIN - 1);
    // Addressed mode ends on the HALT already presented to the CPU, not on the fetch address.
    assign run_end   = mode_q ? is_halt(i_q[DATA_W-1 -: OPC_W])
                              : ({1'b0, idx_q} == prog_len - PL_ONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_o  = 1'b0;
        enable_o = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_START;
            end
            ST_START: begin
                start_o  = 1'b1;
                enable_o = 1'b1;
                state_d  = (prog_len == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                enable_o = 1'b1;
                if (tmo_hit)
                    state_d = ST_DONE;
                else if (run_end)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                enable_o = 1'b1;
                if (drain_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (go) state_d = ST_START;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu.cpu_start  = start_o;
    assign cpu.cpu_enable = enable_o;
    assign cpu.i_datain   = i_q;
    assign cpu.d_datain   = d_q;

    always_ff @(posedge clock) begin
        if (ld_ok && ld_sel == LD_INSTR) instr_mem[ld_idx] <= ld_data;
        if (ld_ok && ld_sel == LD_DATA)  data_mem[ld_idx]  <= ld_data;
    end

    assign err_sum = {1'b0, err_q} + {8'd0, tmo_inc} + {8'd0, st_err};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
            idx_q  <= '0;
            tmo_q  <= '0;
            drn_q  <= '0;
            i_q    <= '0;
            d_q    <= '0;
            err_q  <= '0;
        end else begin
            if (go_clr) begin
                mode_q <= mode;
                idx_q  <= '0;
                tmo_q  <= '0;
            end else if (state_q == ST_RUN) begin
                idx_q <= idx_q + IDX_W'(1);
                tmo_q <= tmo_q + TMO_W'(1);
            end

            drn_q <= (state_q == ST_DRAIN) ? drn_q + DRN_W'(1) : '0;

            case (state_q)
                ST_START: begin
                    i_q <= NOP_WORD;
                    d_q <= '0;
                end
                ST_RUN: begin
                    if (mode_q) begin
                        i_q <= instr_mem[IDX_W'(cpu.i_addr)];
                        d_q <= data_mem[IDX_W'(cpu.d_addr)];
                    end else begin
                        i_q <= instr_mem[idx_q];
                        d_q <= data_mem[idx_q];
                    end
                end
                ST_DRAIN: i_q <= NOP_WORD;
                default: ;
            endcase

            if (go_clr)
                err_q <= '0;
            else
                err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_cnt = err_q;

`ifdef PCPU_STIM_CHECK_EN
    pcpu_store_checker #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .EXP_DEPTH (EXP_DEPTH)
    ) u_checker (
        .clock     (clock),
        .reset     (reset),
        .clr       (go_clr),
        .chk_en    (in_play),
        .ld_we     (ld_ok),
        .ld_sel    (ld_sel),
        .ld_idx    (ld_idx[EIDX_W-1:0]),
        .ld_data   (ld_data),
        .exp_len   (exp_len),
        .d_addr    (cpu.d_addr),
        .d_dataout (cpu.d_dataout),
        .d_we      (cpu.d_we),
        .st_err    (st_err),
        .ptr_done  (ptr_done)
    );

    assign pass = done && (err_q == 8'd0) && ptr_done;
`else
    logic unused_chk;

    assign st_err     = 1'b0;
    assign ptr_done   = 1'b1;
    assign unused_chk = ^{exp_len, cpu.d_dataout, cpu.d_we, in_play, ptr_done};
    assign pass       = done && (err_q == 8'd0);
`endif

    logic unused_addr;
    assign unused_addr = ^{cpu.i_addr, cpu.d_addr};

endmodule

// File: tb/tb_pcpu_stim_player.sv
// tb/tb_pcpu_stim_player.sv - directed self-checking bench for pcpu_stim_player
module tb_pcpu_stim_player;

    logic        clock = 1'b0;
    logic        reset;
    logic        go;
    logic        mode;
    logic        ld_we;
    logic [1:0]  ld_sel;
    logic [4:0]  ld_idx;
    logic [15:0] ld_data;
    logic [5:0]  prog_len;
    logic [3:0]  exp_len;
    logic        done;
    logic        pass;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

`ifdef PCPU_STIM_CHECK_EN
    localparam logic [7:0] BAD_ERR  = 8'd1;
    localparam logic       BAD_PASS = 1'b0;
`else
    localparam logic [7:0] BAD_ERR  = 8'd0;
    localparam logic       BAD_PASS = 1'b1;
`endif

    pcpu_stim_player_if #(.DATA_W(16), .ADDR_W(8)) cpu_if ();

    pcpu_stim_player #(
        .DATA_W    (16),
        .ADDR_W    (8),
        .DEPTH     (32),
        .EXP_DEPTH (8),
        .DRAIN     (8),
        .TIMEOUT   (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .go       (go),
        .mode     (mode),
        .ld_we    (ld_we),
        .ld_sel   (ld_sel),
        .ld_idx   (ld_idx),
        .ld_data  (ld_data),
        .prog_len (prog_len),
        .exp_len  (exp_len),
        .cpu      (cpu_if),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [1:0] sel, input logic [4:0] idx, input logic [15:0] data);
        ld_sel  = sel;
        ld_idx  = idx;
        ld_data = data;
        ld_we   = 1'b1;
        step(1);
        ld_we   = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step(1);
        go = 1'b0;
    endtask

    task automatic store(input logic [7:0] a, input logic [15:0] d);
        cpu_if.d_we      = 1'b1;
        cpu_if.d_addr    = a;
        cpu_if.d_dataout = d;
        step(1);
        cpu_if.d_we      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    32'(cpu_if.cpu_enable), 32'd0);
        check({tag, "_start"}, 32'(cpu_if.cpu_start),  32'd0);
        check({tag, "_idata"}, 32'(cpu_if.i_datain),   32'd0);
        check({tag, "_ddata"}, 32'(cpu_if.d_datain),   32'd0);
        check({tag, "_done"},  32'(done),              32'd0);
        check({tag, "_pass"},  32'(pass),              32'd0);
        check({tag, "_err"},   32'(err_cnt),           32'd0);
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; mode = 1'b0; ld_we = 1'b0;
        ld_sel = '0; ld_idx = '0; ld_data = '0; prog_len = 6'd3; exp_len = 4'd1;
        cpu_if.i_addr = '0; cpu_if.d_addr = '0; cpu_if.d_dataout = '0; cpu_if.d_we = 1'b0;
        step(2);
        check_all_zero("rst");
        reset = 1'b1;
        step(1);

        // LOAD / ADDI 2 / STORE 04, then filler and HALT at entry 5
        load(2'd0, 5'd0, 16'h1000);
        load(2'd0, 5'd1, 16'h3002);
        load(2'd0, 5'd2, 16'h2004);
        load(2'd0, 5'd3, 16'h5001);
        load(2'd0, 5'd4, 16'h5002);
        load(2'd0, 5'd5, 16'hF000);
        load(2'd1, 5'd0, 16'hCCCC);
        load(2'd1, 5'd1, 16'h3BFE);
        load(2'd1, 5'd2, 16'h00AB);
        load(2'd2, 5'd0, 16'h0004);
        load(2'd3, 5'd0, 16'h3C00);

        // timed run with correct expectation
        pulse_go();
        check("start_pulse", 32'(cpu_if.cpu_start), 32'd1);
        check("start_en", 32'(cpu_if.cpu_enable), 32'd1);
        step(1);
        check("start_one_cycle", 32'(cpu_if.cpu_start), 32'd0);
        step(1);
        check("t_i0", 32'(cpu_if.i_datain), 32'h1000);
        check("t_d0", 32'(cpu_if.d_datain), 32'hCCCC);
        step(1);
        check("t_i1", 32'(cpu_if.i_datain), 32'h3002);
        check("t_d1", 32'(cpu_if.d_datain), 32'h3BFE);
        step(1);
        check("t_i2", 32'(cpu_if.i_datain), 32'h2004);
        check("t_d2", 32'(cpu_if.d_datain), 32'h00AB);
        store(8'h04, 16'h3C00);
        check("t_nop", 32'(cpu_if.i_datain), 32'h0000);
        wait_done(40, cyc);
        check("t_drain_lat", 32'(cyc), 32'd7);
        check("t_done_en", 32'(cpu_if.cpu_enable), 32'd0);
        check("t_pass", 32'(pass), 32'd1);
        check("t_err", 32'(err_cnt), 32'd0);

        // wrong expected data
        load(2'd3, 5'd0, 16'h3C01);
        pulse_go();
        check("restart_pulse", 32'(cpu_if.cpu_start), 32'd1);
        step(3);
        store(8'h04, 16'h3C00);
        wait_done(40, cyc);
        check("w_lat", 32'(cyc), 32'd8);
        check("w_err", 32'(err_cnt), 32'(BAD_ERR));
        check("w_pass", 32'(pass), 32'(BAD_PASS));

        // unexpected store, plus a load attempted mid-run that must be ignored
        exp_len = 4'd0;
        pulse_go();
        step(1);
        ld_sel = 2'd0; ld_idx = 5'd0; ld_data = 16'hBEEF; ld_we = 1'b1;
        store(8'h04, 16'h3C00);
        ld_we = 1'b0;
        wait_done(40, cyc);
        check("x_lat", 32'(cyc), 32'd10);
        check("x_err", 32'(err_cnt), 32'(BAD_ERR));
        check("x_pass", 32'(pass), 32'(BAD_PASS));

        // empty program skips RUN
        prog_len = 6'd0;
        pulse_go();
        wait_done(40, cyc);
        check("z_lat", 32'(cyc), 32'd9);
        check("z_pass", 32'(pass), 32'd1);

        // addressed mode, HALT fetched from entry 5
        prog_len = 6'd3;
        mode = 1'b1;
        pulse_go();
        step(1);
        for (int k = 0; k < 6; k++) begin
            cpu_if.i_addr = 8'(k);
            cpu_if.d_addr = 8'd1;
            step(1);
        end
        check("a_halt", 32'(cpu_if.i_datain), 32'hF000);
        check("a_ddata", 32'(cpu_if.d_datain), 32'h3BFE);
        check("a_still_run", 32'(cpu_if.cpu_enable), 32'd1);
        cpu_if.i_addr = 8'd0;
        wait_done(40, cyc);
        check("a_lat", 32'(cyc), 32'd9);
        check("a_pass", 32'(pass), 32'd1);
        check("a_err", 32'(err_cnt), 32'd0);

        // addressed mode never reaching HALT
        pulse_go();
        step(1);
        cyc = 0;
        while (!done && cyc < 40) begin
            cpu_if.i_addr = 8'(cyc % 5);
            step(1);
            cyc++;
        end
        check("to_cycles", 32'(cyc), 32'd16);
        check("to_err", 32'(err_cnt), 32'd1);
        check("to_pass", 32'(pass), 32'd0);

        // reset in the middle of a timed run, then replay
        mode = 1'b0;
        exp_len = 4'd1;
        cpu_if.i_addr = 8'd0;
        load(2'd3, 5'd0, 16'h3C00);
        pulse_go();
        step(1);
        store(8'h55, 16'h0000);
        step(1);
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        step(2);
        reset = 1'b1;
        step(3);
        check("idle_en", 32'(cpu_if.cpu_enable), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        pulse_go();
        step(2);
        check("r_i0", 32'(cpu_if.i_datain), 32'h1000);
        check("r_d0", 32'(cpu_if.d_datain), 32'hCCCC);
        step(2);
        store(8'h04, 16'h3C00);
        wait_done(40, cyc);
        check("r_lat", 32'(cyc), 32'd7);
        check("r_pass", 32'(pass), 32'd1);
        check("r_err", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
